// File: rtl/ifu_fetch.sv
// ifu_fetch: owns the PC, issues in-order imem fetches and buffers {pc, instr} for decode. IFU_MISALIGN_CHK_EN adds a misaligned-redirect halt.
// One cycle from response to if_valid_o; in-flight plus buffered entries are capped at FIFO_DEPTH, so a decode stall throttles requests.

module ifu_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_push_vld,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop_vld,
    output logic [W-1:0]           o_head_dat,
    output logic [$clog2(DEPTH):0] o_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;

    // Overflow is prevented upstream by the credit check, so no full guard here.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push_vld) r_wp <= r_wp + AW'(1);
            if (i_pop_vld)  r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + (AW+1)'(i_push_vld) - (AW+1)'(i_pop_vld);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push_vld && !i_flush) r_mem[r_wp] <= i_push_dat;
    end

    assign o_head_dat = r_mem[r_rp];
    assign o_cnt      = r_cnt;
endmodule

module ifu_fetch #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(32'h8000_0000),
    parameter int                  FIFO_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req_valid_o,
    input  logic                   imem_req_ready_i,
    output logic [PC_WIDTH-1:0]    imem_req_addr_o,
    input  logic                   imem_resp_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic                   if_valid_o,
    input  logic                   if_ready_i,
    output logic [PC_WIDTH-1:0]    if_pc_o,
    output logic [INSTR_WIDTH-1:0] if_instr_o
`ifdef IFU_MISALIGN_CHK_EN
    ,
    output logic                   if_misalign_o
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = PC_WIDTH + INSTR_WIDTH;

    typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH, S_HALT} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [CW-1:0]        r_drop_cnt;
    logic [CW-1:0]        w_drop_nxt;
    logic [PC_WIDTH-1:0]  w_redir_pc;
    logic [PC_WIDTH-1:0]  w_oq_head;
    logic [CW-1:0]        w_oq_cnt;
    logic [FW-1:0]        w_fq_head;
    logic [CW-1:0]        w_fq_cnt;
    logic                 w_misalign;
    logic                 w_halt;
    logic                 w_credit_ok;
    logic                 w_req_vld;
    logic                 w_req_fire;
    logic                 w_resp_drop;
    logic                 w_resp_push;
    logic                 w_fq_vld;
    logic                 w_pop;

`ifdef IFU_MISALIGN_CHK_EN
    assign w_redir_pc = redirect_pc_i;
    assign w_misalign = |redirect_pc_i[1:0];
    assign w_halt     = (r_state == S_HALT);
`else
    logic w_unused_pc_lsb;
    assign w_redir_pc      = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
    assign w_misalign      = 1'b0;
    assign w_halt          = 1'b0;
    assign w_unused_pc_lsb = ^redirect_pc_i[1:0];
`endif

    assign w_fq_vld    = (w_fq_cnt != '0);
    assign w_credit_ok = ({1'b0, w_fq_cnt} + {1'b0, w_oq_cnt}) < (CW+1)'(FIFO_DEPTH);
    assign w_req_fire  = w_req_vld && imem_req_ready_i;
    // Responses in the redirect cycle, during a flush, or while halted belong to the dead path.
    assign w_resp_drop = imem_resp_valid_i && (redirect_i || w_halt || (r_drop_cnt != '0));
    assign w_resp_push = imem_resp_valid_i && !w_resp_drop;
    assign w_pop       = w_fq_vld && if_ready_i && !redirect_i;

    ifu_fifo #(.W(PC_WIDTH), .DEPTH(FIFO_DEPTH)) u_pc_q (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (1'b0),
        .i_push_vld (w_req_fire),
        .i_push_dat (r_pc),
        .i_pop_vld  (imem_resp_valid_i),
        .o_head_dat (w_oq_head),
        .o_cnt      (w_oq_cnt)
    );

    ifu_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_instr_q (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (redirect_i),
        .i_push_vld (w_resp_push),
        .i_push_dat ({w_oq_head, imem_resp_data_i}),
        .i_pop_vld  (w_pop),
        .o_head_dat (w_fq_head),
        .o_cnt      (w_fq_cnt)
    );

    always_comb begin
        w_drop_nxt = r_drop_cnt;
        if (redirect_i) begin
            w_drop_nxt = w_oq_cnt - CW'(imem_resp_valid_i);
        end else if (imem_resp_valid_i && (r_drop_cnt != '0)) begin
            w_drop_nxt = r_drop_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_vld   = 1'b0;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   w_req_vld   = w_credit_ok && !redirect_i;
            S_FLUSH: if (w_drop_nxt == '0) w_state_nxt = S_RUN;
            default: w_state_nxt = r_state;
        endcase
        if (redirect_i) begin
            if (w_misalign) begin
                w_state_nxt = S_HALT;
            end else if (w_drop_nxt != '0) begin
                w_state_nxt = S_FLUSH;
            end else begin
                w_state_nxt = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= w_drop_nxt;
            if (redirect_i) begin
                r_pc <= w_redir_pc;
            end else if (w_req_fire) begin
                r_pc <= r_pc + PC_WIDTH'(4);
            end
        end
    end

    assign imem_req_valid_o = w_req_vld;
    assign imem_req_addr_o  = r_pc;
    assign if_valid_o       = w_fq_vld || w_halt;

    // While halted the PC register still holds the misaligned target, which is the synthetic entry's pc.
    always_comb begin
        if_pc_o    = '0;
        if_instr_o = '0;
        if (w_halt) begin
            if_pc_o = r_pc;
        end else if (w_fq_vld) begin
            {if_pc_o, if_instr_o} = w_fq_head;
        end
    end

`ifdef IFU_MISALIGN_CHK_EN
    assign if_misalign_o = w_halt;
`endif
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: queue-based reference model checked every cycle plus directed literal checks.
module tb_ifu_fetch;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic [31:0] req_addr;
    logic        resp_vld;
    logic [31:0] resp_dat;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_vld;
    logic        if_rdy;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
`ifdef IFU_MISALIGN_CHK_EN
    logic        if_misalign;
`endif

    always #5 clk = ~clk;

    ifu_fetch #(.PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h8000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req_valid_o  (req_vld),
        .imem_req_ready_i  (req_rdy),
        .imem_req_addr_o   (req_addr),
        .imem_resp_valid_i (resp_vld),
        .imem_resp_data_i  (resp_dat),
        .redirect_i        (redirect),
        .redirect_pc_i     (redirect_pc),
        .if_valid_o        (if_vld),
        .if_ready_i        (if_rdy),
        .if_pc_o           (if_pc),
        .if_instr_o        (if_instr)
`ifdef IFU_MISALIGN_CHK_EN
        ,
        .if_misalign_o     (if_misalign)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mem_lat  = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory: accepts every handshake, answers in order after mem_lat cycles with data = ~addr.
    typedef struct { int due; logic [31:0] data; } mresp_t;
    mresp_t      mq[$];
    logic [31:0] fire_log[$];

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            resp_vld = 1'b1;
            resp_dat = mq[0].data;
            void'(mq.pop_front());
        end else begin
            resp_vld = 1'b0;
            resp_dat = 32'hDEAD_BEEF;
        end
    end

    // Reference model: PC, in-flight PCs, buffered {pc, instr}, drop count, mode (0 boot, 1 run, 2 flush).
    logic [31:0] m_pc;
    logic [31:0] m_oq[$];
    logic [31:0] m_fq_pc[$];
    logic [31:0] m_fq_in[$];
    int          m_drop;
    int          m_mode;
    bit          m_init = 1'b0;
    logic        e_req, e_vld, m_pop, m_fire;
    logic [31:0] e_pc, e_in, m_p;

    always @(negedge clk) begin
        e_req = (m_mode == 1) && ((m_fq_pc.size() + m_oq.size()) < DEPTH) && !redirect;
        e_vld = (m_fq_pc.size() > 0);
        e_pc  = 32'h0;
        e_in  = 32'h0;
        if (e_vld) begin
            e_pc = m_fq_pc[0];
            e_in = m_fq_in[0];
        end
        if (m_init) begin
            chk("req_valid", 32'(req_vld), 32'(e_req));
            chk("req_addr",  req_addr, m_pc);
            chk("if_valid",  32'(if_vld), 32'(e_vld));
            chk("if_pc",     if_pc, e_pc);
            chk("if_instr",  if_instr, e_in);
            if (!rst && if_vld && if_rdy && !redirect) chk("deliv_pair", if_instr, ~if_pc);
        end
        if (!rst && req_vld && req_rdy) begin
            fire_log.push_back(req_addr);
            mq.push_back('{cyc + mem_lat, ~req_addr});
        end
        if (rst) begin
            mq.delete();
            m_pc = 32'h8000_0000;
            m_oq.delete();
            m_fq_pc.delete();
            m_fq_in.delete();
            m_drop = 0;
            m_mode = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            m_pop  = e_vld && if_rdy;
            m_fire = e_req && req_rdy;
            if (redirect) begin
                if (resp_vld && m_oq.size() > 0) void'(m_oq.pop_front());
                m_fq_pc.delete();
                m_fq_in.delete();
                m_pc   = {redirect_pc[31:2], 2'b00};
                m_drop = m_oq.size();
                m_mode = (m_drop > 0) ? 2 : 1;
            end else begin
                if (m_pop) begin
                    void'(m_fq_pc.pop_front());
                    void'(m_fq_in.pop_front());
                end
                if (resp_vld && m_oq.size() > 0) begin
                    m_p = m_oq.pop_front();
                    if (m_drop > 0) begin
                        m_drop--;
                    end else begin
                        m_fq_pc.push_back(m_p);
                        m_fq_in.push_back(resp_dat);
                    end
                end
                if (m_fire) begin
                    m_oq.push_back(m_pc);
                    m_pc = m_pc + 32'd4;
                end
                if (m_mode == 0) m_mode = 1;
                else if (m_mode == 2 && m_drop == 0) m_mode = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fires(input int n, input int budget);
        int k = 0;
        while (fire_log.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        if (fire_log.size() < n) chk("fire_timeout", 32'(fire_log.size()), 32'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          f0;
        bit          found;
        logic [15:0] rpat;
        logic [15:0] ipat;
        rst = 1'b1; req_rdy = 1'b1; if_rdy = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        resp_vld = 1'b0; resp_dat = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Boot cycle, first request, first delivery three cycles after release.
        @(negedge clk);
        chk("boot_no_req", 32'(req_vld), 32'd0);
        chk("boot_no_if_valid", 32'(if_vld), 32'd0);
        @(negedge clk);
        chk("first_req_vld", 32'(req_vld), 32'd1);
        chk("first_req_addr", req_addr, 32'h8000_0000);
        @(negedge clk);
        chk("second_req_addr", req_addr, 32'h8000_0004);
        chk("c2_if_valid", 32'(if_vld), 32'd0);
        @(negedge clk);
        chk("first_if_valid", 32'(if_vld), 32'd1);
        chk("first_if_pc", if_pc, 32'h8000_0000);
        chk("first_if_instr", if_instr, 32'h7FFF_FFFF);
        repeat (20) @(negedge clk);

        // Mid-run reset, then decode stalled: exactly two requests.
        tick(); rst = 1'b1; if_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        f0 = fire_log.size();
        repeat (10) @(negedge clk);
        chk("stall_fires", 32'(fire_log.size() - f0), 32'd2);
        chk("stall_req_vld", 32'(req_vld), 32'd0);
        chk("stall_head_pc", if_pc, 32'h8000_0000);

        // One pop re-enables exactly one request.
        tick(); if_rdy = 1'b1;
        tick(); if_rdy = 1'b0;
        f0 = fire_log.size();
        repeat (6) @(negedge clk);
        chk("pop_one_req", 32'(fire_log.size() - f0), 32'd1);
        chk("pop_head_pc", if_pc, 32'h8000_0004);

        // Memory not ready for 5 cycles: address held.
        tick(); req_rdy = 1'b0; if_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("held_addr", req_addr, 32'h8000_000C);
        end
        chk("held_req_vld", 32'(req_vld), 32'd1);

        // Two outstanding requests, then redirect: both responses dropped.
        mem_lat = 4;
        tick(); req_rdy = 1'b1;
        tick();
        tick(); req_rdy = 1'b0; redirect = 1'b1; redirect_pc = 32'h8000_0100;
        chk("pre_redir_fire0", fire_log[fire_log.size()-2], 32'h8000_000C);
        chk("pre_redir_fire1", fire_log[fire_log.size()-1], 32'h8000_0010);
        fire_log.delete();
        tick(); redirect = 1'b0; req_rdy = 1'b1;
        @(negedge clk);
        chk("flush_addr", req_addr, 32'h8000_0100);
        chk("flush_no_req", 32'(req_vld), 32'd0);
        chk("flush_if_valid", 32'(if_vld), 32'd0);
        wait_fires(1, 30);
        if (fire_log.size() > 0) chk("post_flush_addr", fire_log[0], 32'h8000_0100);

        // Redirect coinciding with a response and a decode pop.
        mem_lat = 1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #2;
            if (if_vld && resp_vld) found = 1'b1;
        end
        if (!found) chk("coincide_timeout", 32'd0, 32'd1);
        redirect = 1'b1; redirect_pc = 32'h8000_0200;
        tick(); redirect = 1'b0;
        @(negedge clk);
        chk("coincide_if_valid", 32'(if_vld), 32'd0);
        chk("coincide_pc", req_addr, 32'h8000_0200);

        // Target low bits are cleared on load.
        tick(); redirect = 1'b1; redirect_pc = 32'h8000_0302;
        tick(); redirect = 1'b0;
        @(negedge clk);
        chk("align_force", req_addr, 32'h8000_0300);

        // PC wraps from 0xFFFFFFFC to 0.
        tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        fire_log.delete();
        tick(); redirect = 1'b0;
        wait_fires(2, 40);
        if (fire_log.size() > 1) begin
            chk("wrap_addr0", fire_log[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", fire_log[1], 32'h0000_0000);
        end

        // Mixed backpressure with redirects, including one during a flush.
        rpat = 16'b1011_0111_0010_1101;
        ipat = 16'b1101_1010_0111_1001;
        for (int i = 0; i < 64; i++) begin
            tick();
            req_rdy     = rpat[i % 16];
            if_rdy      = ipat[(i * 3) % 16];
            mem_lat     = 1 + (i % 3);
            redirect    = (i == 30 || i == 33);
            redirect_pc = (i == 30) ? 32'h8000_1000 : 32'h8000_2004;
        end
        tick(); redirect = 1'b0; req_rdy = 1'b1; if_rdy = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
